sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single on-chip SRAM port pair (read: raddr/ren/rdata; write: waddr/wdata/wen) between two requesters.
- Requester 0 is the AXI-to-SRAM bridge on the CPU side. Requester 1 is a secondary master, such as a debug/program loader or DMA.
- Arbitration is round-robin, with an optional per-requester lock for back-to-back bursts, bounded by a hold counter.
- Routes synchronous-read return data back to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 32, requester and SRAM byte-address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- MAX_HOLD, 8, maximum consecutive locked grants to one requester while the other is pending; legal range 1..255.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-high
- req0  in  1  requester 0 access request
- we0  in  1  1 = write, 0 = read
- lock0  in  1  request to keep ownership for the next access
- addr0  in  ADDR_WIDTH  byte address
- wdata0  in  DATA_WIDTH  write data
- wstrb0  in  DATA_WIDTH/8  byte strobes, writes only
- gnt0  out  1  access accepted this cycle
- rvalid0  out  1  read data valid
- rdata0  out  DATA_WIDTH  read data
- req1, we1, lock1, addr1, wdata1, wstrb1, gnt1, rvalid1, rdata1  same as requester 0, for requester 1
- ram_raddr  out  ADDR_WIDTH  SRAM read address
- ram_ren  out  1  SRAM read enable
- ram_rdata  in  DATA_WIDTH  SRAM read data, valid one cycle after ram_ren
- ram_waddr  out  ADDR_WIDTH  SRAM write address
- ram_wdata  out  DATA_WIDTH  SRAM write data
- ram_wen  out  DATA_WIDTH/8  SRAM byte write enables

Behaviour:
- Clock and reset: clk, with reset resetn, asynchronous, active-high.
- Throughput: at most one access (read or write) is granted per cycle.
- Grant timing:
  - The grant is combinational from the req inputs and registered arbiter state.
  - A requester samples gnt in the same cycle it holds req.
  - A transfer occurs when reqN && gntN.
  - Requesters hold req/we/addr/wdata/wstrb stable until granted.
- Registered state:
  - last_owner, 1 bit.
  - locked, 1 bit.
  - hold_cnt, 8 bits.
  - rd_pend, 1 bit.
  - rd_id, 1 bit.
- Owner selection, evaluated each cycle:
  - No req: no grant. locked is cleared; last_owner is unchanged.
  - Exactly one req: that requester is granted.
  - Both req, and (locked && hold_cnt < MAX_HOLD): last_owner is granted again.
  - Both req otherwise: the requester != last_owner is granted (round-robin).
- State update on a grant to requester g:
  - last_owner <= g.
  - locked <= lockg.
  - hold_cnt: if g == previous last_owner && locked, hold_cnt <= hold_cnt+1, saturating at 255. Otherwise hold_cnt <= 1.
- lock raised by the non-owner has no effect until that requester wins a grant.
- SRAM drive, all combinational from the granted request:
  - Read grant: ram_ren = 1, ram_raddr = addrg, ram_wen = 0.
  - Write grant: ram_wen = wstrbg, ram_waddr = addrg, ram_wdata = wdatag, ram_ren = 0.
  - No grant: ram_ren = 0, ram_wen = 0. Addresses and data hold their last values (don't-care).
  - A write with wstrb = 0 is still granted and consumes the slot; ram_wen = 0.
- Read return:
  - On a read grant, rd_pend <= 1 and rd_id <= g; otherwise rd_pend <= 0.
  - rvalidN = rd_pend && rd_id == N, with latency exactly 1 cycle after the grant.
  - rdataN = ram_rdata when rvalidN; 0 otherwise.
  - Back-to-back reads alternating requesters return in order, one per cycle.
- No read/write hazard forwarding. A read in the cycle after a write to the same address returns whatever the SRAM returns.
- Reset (resetn = 1):
  - last_owner = 1, so requester 0 wins the first tie.
  - locked = 0, hold_cnt = 0, rd_pend = 0, rd_id = 0.
  - gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0.
  - ram_ren = 0, ram_wen = 0, ram_raddr/ram_waddr/ram_wdata = 0.
  - Reset asserted mid-read: a pending rvalid is dropped and no data is returned.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- When defined, adds outputs:
  - perf_gnt0, 32 bits: saturating count of grants to requester 0.
  - perf_gnt1, 32 bits: saturating count of grants to requester 1.
  - perf_stall, 32 bits: saturating count of cycles in which both req are high and one requester is denied.
  - All three reset to 0, count while resetn = 0, and hold at 32'hFFFFFFFF when saturated.
  - Input perf_clr, 1 bit: synchronous clear of all three counters; has priority over counting.
- When undefined, these ports and counters are absent and the arbiter behaviour is identical.

Test Plan:
- Reset then req0 = 1, req1 = 1, both reads, addr0 = 0x10, addr1 = 0x20, held 4 cycles -> grants alternate 0,1,0,1. ram_raddr goes 0x10,0x20,0x10,0x20. rvalid0 and rvalid1 alternate, delayed 1 cycle, each carrying its own ram_rdata.
- req0 only, write addr0 = 0x40, wdata0 = 0xDEADBEEF, wstrb0 = 4'b0011 -> gnt0 = 1 the same cycle. ram_wen = 4'b0011, ram_waddr = 0x40, ram_wdata = 0xDEADBEEF. No rvalid pulse.
- req0 with lock0 = 1 continuously, req1 = 1 continuously, MAX_HOLD = 8 -> requester 0 is granted 8 consecutive cycles, then gnt1 = 1 for one cycle, then requester 0 again.
- Read granted to requester 1 at cycle N with ram_rdata = 0x12345678 at N+1 -> rvalid1 = 1 and rdata1 = 0x12345678 at N+1. rvalid0 = 0 and rdata0 = 0.
- Read granted, then resetn asserted before the next edge -> rvalid0 = rvalid1 = 0. After release with both req high, the first grant goes to requester 0.
- With SRAM_ARB_PERF_EN: 10 cycles of both requesters requesting without lock -> perf_gnt0 = 5, perf_gnt1 = 5, perf_stall = 10. Pulsing perf_clr -> all counters = 0 on the next cycle.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM signal bundle for the two-port SRAM arbiter.
// slave = arbiter side, master = requesters plus SRAM model side.
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req0, we0, lock0;
  logic [ADDR_WIDTH-1:0]   addr0;
  logic [DATA_WIDTH-1:0]   wdata0;
  logic [DATA_WIDTH/8-1:0] wstrb0;
  logic                    gnt0, rvalid0;
  logic [DATA_WIDTH-1:0]   rdata0;

  logic                    req1, we1, lock1;
  logic [ADDR_WIDTH-1:0]   addr1;
  logic [DATA_WIDTH-1:0]   wdata1;
  logic [DATA_WIDTH/8-1:0] wstrb1;
  logic                    gnt1, rvalid1;
  logic [DATA_WIDTH-1:0]   rdata1;

  logic [ADDR_WIDTH-1:0]   ram_raddr, ram_waddr;
  logic                    ram_ren;
  logic [DATA_WIDTH-1:0]   ram_rdata, ram_wdata;
  logic [DATA_WIDTH/8-1:0] ram_wen;

  modport slave (
    input  req0, we0, lock0, addr0, wdata0, wstrb0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, lock1, addr1, wdata1, wstrb1,
    output gnt1, rvalid1, rdata1,
    output ram_raddr, ram_ren, ram_waddr, ram_wdata, ram_wen,
    input  ram_rdata
  );

  modport master (
    output req0, we0, lock0, addr0, wdata0, wstrb0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, lock1, addr1, wdata1, wstrb1,
    input  gnt1, rvalid1, rdata1,
    input  ram_raddr, ram_ren, ram_waddr, ram_wdata, ram_wen,
    output ram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with bounded lock sharing one SRAM read/write port pair between two requesters.
// Grant is combinational (same cycle), read data returns 1 cycle later; SRAM_ARB_PERF_EN adds perf counters.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_port_arbiter_if.slave    bus
`ifdef SRAM_ARB_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [31:0]           perf_gnt0,
  output logic [31:0]           perf_gnt1,
  output logic [31:0]           perf_stall
`endif
);
  localparam int             SW         = DATA_WIDTH / 8;
  localparam logic [7:0]     MAX_HOLD_C = 8'(MAX_HOLD);

  logic                  last_owner, locked, rd_pend, rd_id;
  logic [7:0]            hold_cnt;
  logic [ADDR_WIDTH-1:0] raddr_q, waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  any_gnt, gsel, g_we, g_lock, rd_gnt, wr_gnt;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [SW-1:0]         g_wstrb;

  always_comb begin
    any_gnt = 1'b0;
    gsel    = 1'b0;
    if (!resetn) begin
      if (bus.req0 && bus.req1) begin
        any_gnt = 1'b1;
        gsel    = (locked && (hold_cnt < MAX_HOLD_C)) ? last_owner : ~last_owner;
      end else if (bus.req0) begin
        any_gnt = 1'b1;
        gsel    = 1'b0;
      end else if (bus.req1) begin
        any_gnt = 1'b1;
        gsel    = 1'b1;
      end
    end
  end

  assign g_we    = gsel ? bus.we1    : bus.we0;
  assign g_lock  = gsel ? bus.lock1  : bus.lock0;
  assign g_addr  = gsel ? bus.addr1  : bus.addr0;
  assign g_wdata = gsel ? bus.wdata1 : bus.wdata0;
  assign g_wstrb = gsel ? bus.wstrb1 : bus.wstrb0;
  assign rd_gnt  = any_gnt && !g_we;
  assign wr_gnt  = any_gnt && g_we;

  assign bus.gnt0 = any_gnt && !gsel;
  assign bus.gnt1 = any_gnt && gsel;

  // Idle cycles present the last address/data so the SRAM pins do not toggle.
  assign bus.ram_ren   = rd_gnt;
  assign bus.ram_raddr = rd_gnt ? g_addr : raddr_q;
  assign bus.ram_wen   = wr_gnt ? g_wstrb : '0;
  assign bus.ram_waddr = wr_gnt ? g_addr : waddr_q;
  assign bus.ram_wdata = wr_gnt ? g_wdata : wdata_q;

  assign bus.rvalid0 = rd_pend && !rd_id;
  assign bus.rvalid1 = rd_pend && rd_id;
  assign bus.rdata0  = bus.rvalid0 ? bus.ram_rdata : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.ram_rdata : '0;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      last_owner <= 1'b1;
      locked     <= 1'b0;
      hold_cnt   <= 8'd0;
      rd_pend    <= 1'b0;
      rd_id      <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      rd_pend <= rd_gnt;
      if (rd_gnt) begin
        rd_id   <= gsel;
        raddr_q <= g_addr;
      end
      if (wr_gnt) begin
        waddr_q <= g_addr;
        wdata_q <= g_wdata;
      end
      if (any_gnt) begin
        last_owner <= gsel;
        locked     <= g_lock;
        if ((gsel == last_owner) && locked)
          hold_cnt <= (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
        else
          hold_cnt <= 8'd1;
      end else begin
        locked <= 1'b0;
      end
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic stall;
  assign stall = bus.req0 && bus.req1 && !resetn;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      perf_gnt0  <= 32'd0;
      perf_gnt1  <= 32'd0;
      perf_stall <= 32'd0;
    end else if (perf_clr) begin
      perf_gnt0  <= 32'd0;
      perf_gnt1  <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      if (bus.gnt0 && (perf_gnt0 != 32'hFFFF_FFFF))  perf_gnt0  <= perf_gnt0 + 32'd1;
      if (bus.gnt1 && (perf_gnt1 != 32'hFFFF_FFFF))  perf_gnt1  <= perf_gnt1 + 32'd1;
      if (stall && (perf_stall != 32'hFFFF_FFFF))    perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule
